// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg
//   Shared types and default constants for the run controller that sits
//   beside the single-cycle mips core in the simulation top level.
//   Contents:
//     run_state_t      - controller state (HOLD, RUN, HALTED, TIMEOUT)
//     PC_RESET         - PC the core starts from after its reset
//     HALT_REPEAT_DEF  - default number of repeated PC samples meaning "halt"
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } run_state_t;

  localparam logic [31:0] PC_RESET        = 32'h0000_3000;
  localparam int          HALT_REPEAT_DEF = 4;

endpackage

// File: rtl/pc_stable_detect.sv
// pc_stable_detect
//   Watches the core PC while the program runs and flags a self-loop
//   (e.g. "beq $0,$0,-1"): the PC sampled HALT_REPEAT times in a row with the
//   same value as the previously sampled PC.
//   Ports:
//     clk     in   clock, rising edge
//     clear   in   synchronous clear of the PC history and repeat counter
//     sample  in   take a PC sample this edge
//     pc      in   PC_W  current core PC
//     stable  out  one-cycle pulse, high during the cycle whose edge samples
//                  the HALT_REPEAT-th repeat of a PC value
module pc_stable_detect #(
  parameter int PC_W        = 32,
  parameter int HALT_REPEAT = 4
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            sample,
  input  logic [PC_W-1:0] pc,
  output logic            stable
);

  localparam int               REP_W    = $clog2(HALT_REPEAT + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(HALT_REPEAT - 1);
  localparam logic [REP_W-1:0] REP_MAX  = REP_W'(HALT_REPEAT);

  logic            r_have_last;
  logic [PC_W-1:0] r_last_pc;
  logic [REP_W-1:0] r_rep_cnt;
  logic            w_same;

  // The first sample of a run only primes the history; it never counts as a repeat.
  assign w_same = r_have_last && (pc == r_last_pc);

  // Combinational so the controller can stop on the very edge that samples
  // the final repeat.
  assign stable = sample && w_same && (r_rep_cnt == REP_LAST);

  always_ff @(posedge clk) begin
    if (clear) begin
      r_have_last <= 1'b0;
      r_last_pc   <= '0;
      r_rep_cnt   <= '0;
    end else if (sample) begin
      if (!r_have_last) begin
        r_have_last <= 1'b1;
        r_last_pc   <= pc;
      end else if (w_same) begin
        if (r_rep_cnt != REP_MAX) begin
          r_rep_cnt <= r_rep_cnt + REP_W'(1);
        end
      end else begin
        r_rep_cnt <= '0;
        r_last_pc <= pc;
      end
    end
  end

endmodule

// File: rtl/run_controller.sv
// run_controller
//   Run control for the mips core in simulation: stretches reset to the core,
//   counts executed cycles, detects program end as a PC self-loop and raises
//   sticky halted / timed_out flags. A restart pulse reruns the program
//   without a global reset.
//   Ports:
//     clk          in   clock, rising edge
//     reset        in   synchronous active-high reset, overrides all inputs
//     restart      in   single-cycle request to rerun the program
//     pc           in   PC_W  current core PC (ignored outside RUN)
//     cpu_reset    out  reset driven to the core
//     running      out  high while in RUN
//     halted       out  sticky, self-loop detected
//     timed_out    out  sticky, run reached MAX_CYCLES
//     done         out  halted | timed_out
//     cycle_count  out  CNT_W  RUN cycles executed (saturating)
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int RST_CYCLES  = 1,
  parameter int HALT_REPEAT = HALT_REPEAT_DEF,
  parameter int MAX_CYCLES  = 100000,
  parameter int CNT_W       = 32,
  parameter int PC_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_reset,
  output logic             running,
  output logic             halted,
  output logic             timed_out,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int                HOLD_W    = $clog2(RST_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MAX_CYCLES);

  run_state_t       r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] r_cycle_count;
  logic             r_cpu_reset;
  logic             r_running;
  logic             r_halted;
  logic             r_timed_out;

  logic             w_clear;
  logic             w_sample;
  logic             w_stable;
  logic [CNT_W-1:0] w_count_inc;
  logic             w_limit_hit;

  // Any reset/restart, or simply being outside RUN, wipes the PC history so
  // every run starts by priming it afresh.
  assign w_clear  = reset || restart || (r_state != ST_RUN);
  assign w_sample = (r_state == ST_RUN);

  pc_stable_detect #(
    .PC_W        (PC_W),
    .HALT_REPEAT (HALT_REPEAT)
  ) u_pc_stable_detect (
    .clk    (clk),
    .clear  (w_clear),
    .sample (w_sample),
    .pc     (pc),
    .stable (w_stable)
  );

  assign w_count_inc = (&r_cycle_count) ? r_cycle_count : r_cycle_count + CNT_W'(1);
  assign w_limit_hit = (MAX_CYCLES != 0) && (w_count_inc == CNT_LIMIT);

  always_ff @(posedge clk) begin
    // restart is indistinguishable from reset in every state, including HOLD
    // where it simply restarts the hold count.
    if (reset || restart) begin
      r_state       <= ST_HOLD;
      r_hold_cnt    <= '0;
      r_cycle_count <= '0;
      r_cpu_reset   <= 1'b1;
      r_running     <= 1'b0;
      r_halted      <= 1'b0;
      r_timed_out   <= 1'b0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          // Compare against RST_CYCLES-1: this edge's increment reaches RST_CYCLES.
          if (r_hold_cnt == HOLD_LAST) begin
            r_state     <= ST_RUN;
            r_hold_cnt  <= '0;
            r_cpu_reset <= 1'b0;
            r_running   <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          r_cycle_count <= w_count_inc;
          // Halt takes priority when both conditions land on the same edge.
          if (w_stable) begin
            r_state   <= ST_HALTED;
            r_running <= 1'b0;
            r_halted  <= 1'b1;
          end else if (w_limit_hit) begin
            r_state     <= ST_TIMEOUT;
            r_running   <= 1'b0;
            r_timed_out <= 1'b1;
          end
        end
        ST_HALTED, ST_TIMEOUT: begin
          // Terminal: count and flags frozen, core left spinning out of reset.
        end
        default: begin
          r_state <= ST_HOLD;
        end
      endcase
    end
  end

  assign cpu_reset   = r_cpu_reset;
  assign running     = r_running;
  assign halted      = r_halted;
  assign timed_out   = r_timed_out;
  assign done        = r_halted | r_timed_out;
  assign cycle_count = r_cycle_count;

endmodule
